// File: rtl/match_sequencer.sv
// Match-level sequencer around a game core: rounds, scores, result hold and champion.
// Optional MOVE_TIMEOUT_EN adds a per-move timer that forfeits the round to the waiting side.
module match_sequencer #(
  parameter int WINS_TO_MATCH = 3,
  parameter int RESULT_HOLD   = 4,
  parameter int TIMEOUT_CYC   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       winA,
  input  logic       winB,
  input  logic       tie,
  input  logic       turn,
  input  logic       move_done,
  output logic       game_rst,
  output logic       first_player,
  output logic [3:0] scoreA,
  output logic [3:0] scoreB,
  output logic [3:0] round,
  output logic       match_over,
  output logic [1:0] champion,
  output logic       timeout
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLAY, S_HOLD, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  scoreA_q, scoreA_d, scoreB_q, scoreB_d, round_q, round_d;
  logic        fp_q, fp_d, first_q, first_d;
  logic [1:0]  champ_q, champ_d;
  logic [7:0]  hold_q, hold_d;

  logic res_vld, expire, hold_end, won, restart, incA, incB;

  // Core flags are stale in the first PLAY cycle after a clear, so they are masked then.
  assign res_vld  = (state_q == S_PLAY) && !first_q && (winA || winB || tie);
  assign hold_end = (state_q == S_HOLD) && (hold_q == 8'(RESULT_HOLD - 1));
  assign won      = (scoreA_q == 4'(WINS_TO_MATCH)) || (scoreB_q == 4'(WINS_TO_MATCH));
  assign restart  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

`ifdef MOVE_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;

  assign expire = (state_q == S_PLAY) && !res_vld && !move_done &&
                  (timer_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    timer_d = '0;
    if (state_q == S_PLAY && !move_done) timer_d = timer_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  // A forfeit goes to the side that is not on move.
  assign incA = (res_vld && winA) || (expire && turn);
  assign incB = (res_vld && !winA && winB) || (expire && !turn);
`else
  logic unused_in;
  assign unused_in = turn ^ move_done;
  assign expire    = 1'b0;
  assign incA      = res_vld && winA;
  assign incB      = res_vld && !winA && winB;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      scoreA_q <= '0;
      scoreB_q <= '0;
      round_q  <= '0;
      fp_q     <= 1'b0;
      first_q  <= 1'b0;
      champ_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      scoreA_q <= scoreA_d;
      scoreB_q <= scoreB_d;
      round_q  <= round_d;
      fp_q     <= fp_d;
      first_q  <= first_d;
      champ_q  <= champ_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_PLAY;
      S_PLAY:  if (res_vld || expire) state_d = S_HOLD;
      S_HOLD:  if (hold_end) state_d = won ? S_DONE : S_CLEAR;
      S_DONE:  if (start) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scoreA_d = scoreA_q;
    scoreB_d = scoreB_q;
    round_d  = round_q;
    fp_d     = fp_q;
    champ_d  = champ_q;
    first_d  = (state_q == S_CLEAR);
    hold_d   = (state_q == S_HOLD) ? hold_q + 8'd1 : 8'd0;
    if (restart) begin
      scoreA_d = '0;
      scoreB_d = '0;
      round_d  = 4'd1;
      fp_d     = 1'b0;
      champ_d  = '0;
    end
    if (incA && scoreA_q != 4'hF) scoreA_d = scoreA_q + 4'd1;
    if (incB && scoreB_q != 4'hF) scoreB_d = scoreB_q + 4'd1;
    if (hold_end) begin
      if (won) begin
        champ_d = (scoreA_q == 4'(WINS_TO_MATCH)) ? 2'b01 : 2'b10;
      end else begin
        if (round_q != 4'hF) round_d = round_q + 4'd1;
        fp_d = ~fp_q;
      end
    end
  end

  always_comb begin
    game_rst   = (state_q == S_CLEAR);
    match_over = (state_q == S_DONE);
    timeout    = expire;
  end

  assign first_player = fp_q;
  assign scoreA       = scoreA_q;
  assign scoreB       = scoreB_q;
  assign round        = round_q;
  assign champion     = champ_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed match scenarios with literal checks, then random
// stimulus compared every cycle against a countdown-style match model.
module tb_match_sequencer;

  localparam int W  = 3;
  localparam int RH = 4;
  localparam int TO = 8;

  localparam int M_IDLE = 0, M_CLEAR = 1, M_PLAY = 2, M_HOLD = 3, M_DONE = 4;

  logic clk, rst, start, winA, winB, tie, turn, move_done;
  logic game_rst, first_player, match_over, timeout;
  logic [3:0] scoreA, scoreB, round;
  logic [1:0] champion;

  int total = 0;
  int bad   = 0;

  match_sequencer #(.WINS_TO_MATCH(W), .RESULT_HOLD(RH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .winA(winA), .winB(winB), .tie(tie),
    .turn(turn), .move_done(move_done), .game_rst(game_rst),
    .first_player(first_player), .scoreA(scoreA), .scoreB(scoreB), .round(round),
    .match_over(match_over), .champion(champion), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // Match model: phase plus countdowns, advanced once per cycle from the sampled inputs.
  int  m_mode = M_IDLE, m_sa = 0, m_sb = 0, m_rnd = 0, m_fp = 0, m_ch = 0;
  int  m_age = 0, m_idle = 0, m_hold = 0;
  bit  m_ok = 0;

  function automatic int sat15(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  always @(negedge clk) begin
    bit flag, exp_to;
    flag   = (m_mode == M_PLAY) && (m_age > 0) && (winA || winB || tie);
    exp_to = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    exp_to = (m_mode == M_PLAY) && !flag && !move_done && (m_idle == TO - 1);
`endif
    if (m_ok) begin
      chk("game_rst", int'(game_rst), int'(m_mode == M_CLEAR));
      chk("match_over", int'(match_over), int'(m_mode == M_DONE));
      chk("timeout", int'(timeout), int'(exp_to));
      chk("scoreA", int'(scoreA), m_sa);
      chk("scoreB", int'(scoreB), m_sb);
      chk("round", int'(round), m_rnd);
      chk("first_player", int'(first_player), m_fp);
      chk("champion", int'(champion), m_ch);
    end
    if (rst) begin
      m_ok = 1; m_mode = M_IDLE; m_sa = 0; m_sb = 0; m_rnd = 0; m_fp = 0; m_ch = 0;
      m_age = 0; m_idle = 0; m_hold = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: if (start) begin
          m_sa = 0; m_sb = 0; m_ch = 0; m_rnd = 1; m_fp = 0; m_mode = M_CLEAR;
        end
        M_CLEAR: begin
          m_mode = M_PLAY; m_age = 0; m_idle = 0;
        end
        M_PLAY: begin
          if (flag) begin
            if (winA) m_sa = sat15(m_sa);
            else if (winB) m_sb = sat15(m_sb);
            m_mode = M_HOLD; m_hold = RH;
          end else if (exp_to) begin
            if (turn) m_sa = sat15(m_sa);
            else m_sb = sat15(m_sb);
            m_mode = M_HOLD; m_hold = RH;
          end else begin
            m_age++;
            m_idle = move_done ? 0 : m_idle + 1;
          end
        end
        M_HOLD: begin
          m_hold--;
          if (m_hold == 0) begin
            if (m_sa == W) begin m_ch = 1; m_mode = M_DONE; end
            else if (m_sb == W) begin m_ch = 2; m_mode = M_DONE; end
            else begin m_rnd = (m_rnd >= 15) ? 15 : m_rnd + 1; m_fp ^= 1; m_mode = M_CLEAR; end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  // Entered with the DUT in CLEAR; leaves it in the following CLEAR or DONE cycle.
  task automatic round_result(input bit a, input bit b, input bit t);
    tick();
    tick();
    winA = a; winB = b; tie = t;
    tick();
    winA = 0; winB = 0; tie = 0;
    repeat (RH - 1) tick();
    tick();
  endtask

  initial begin
    int p_flag, p_md, p_st, seg;
    rst = 1; start = 0; winA = 0; winB = 0; tie = 0; turn = 0; move_done = 0;
    tick(); tick();
    rst = 0;
    peek();
    chk("lit_reset_round", int'(round), 0);
    chk("lit_reset_champion", int'(champion), 0);
    chk("lit_reset_game_rst", int'(game_rst), 0);

    // Three straight A wins with default match length.
    tick();
    start = 1;
    tick();
    start = 0;
    peek();
    chk("lit_clear_game_rst", int'(game_rst), 1);
    chk("lit_clear_round", int'(round), 1);
    for (int r = 1; r <= 3; r++) begin
      tick(); tick();
      winA = 1;
      tick();
      winA = 0;
      peek();
      chk("lit_win_scoreA", int'(scoreA), r);
      chk("lit_win_round", int'(round), r);
      chk("lit_win_fp", int'(first_player), (r - 1) % 2);
      tick(); tick(); tick(); tick();
      peek();
      if (r < 3) chk("lit_next_clear", int'(game_rst), 1);
    end
    chk("lit_done_over", int'(match_over), 1);
    chk("lit_done_champ", int'(champion), 1);
    chk("lit_done_no_clear", int'(game_rst), 0);
    tick(); tick();

    // Simultaneous flags, then a tie.
    start = 1;
    tick();
    start = 0;
    round_result(1, 1, 0);
    peek();
    chk("lit_prio_scoreA", int'(scoreA), 1);
    chk("lit_prio_scoreB", int'(scoreB), 0);
    round_result(0, 0, 1);
    peek();
    chk("lit_tie_round", int'(round), 3);
    chk("lit_tie_scoreA", int'(scoreA), 1);

    // Reset mid-HOLD with B on two wins; start during PLAY is ignored.
    tick();
    rst = 1;
    tick();
    rst = 0; start = 1;
    tick();
    start = 0;
    round_result(0, 1, 0);
    round_result(0, 1, 0);
    tick();
    start = 1;
    tick();
    start = 0; tie = 1;
    tick();
    tie = 0;
    peek();
    chk("lit_hold_scoreB", int'(scoreB), 2);
    chk("lit_hold_round", int'(round), 3);
    tick();
    rst = 1;
    tick();
    rst = 0;
    peek();
    chk("lit_rst_scoreB", int'(scoreB), 0);
    chk("lit_rst_round", int'(round), 0);

    // Sixteen ties: round sticks at 15.
    tick();
    start = 1;
    tick();
    start = 0;
    repeat (16) round_result(0, 0, 1);
    peek();
    chk("lit_round_sat", int'(round), 15);

`ifdef MOVE_TIMEOUT_EN
    tick();
    rst = 1;
    tick();
    rst = 0; start = 1;
    tick();
    start = 0; turn = 1;
    repeat (TO) tick();
    peek();
    chk("lit_timeout_pulse", int'(timeout), 1);
    tick();
    peek();
    chk("lit_timeout_scoreA", int'(scoreA), 1);
    chk("lit_timeout_once", int'(timeout), 0);
    repeat (RH) tick();
    begin
      int n_to;
      n_to = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        move_done = (i % 5 == 4);
        peek();
        if (timeout) n_to++;
      end
      tick();
      move_done = 0;
      chk("lit_no_timeout_with_moves", n_to, 0);
    end
    turn = 0;
`endif

    // Randomized segments with differing flag densities.
    for (int c = 0; c < 4000; c++) begin
      seg = (c / 500) % 4;
      case (seg)
        0: begin p_flag = 8;  p_md = 3; p_st = 8; end
        1: begin p_flag = 50; p_md = 6; p_st = 6; end
        2: begin p_flag = 4;  p_md = 2; p_st = 6; end
        default: begin p_flag = 3; p_md = 4; p_st = 10; end
      endcase
      tick();
      rst       = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, p_st - 1) == 0);
      move_done = ($urandom_range(0, p_md - 1) == 0);
      turn      = $urandom_range(0, 1) != 0;
      tie       = ($urandom_range(0, p_flag - 1) == 0);
      if (seg == 2) begin
        winA = 0; winB = 0;
      end else begin
        winA = ($urandom_range(0, p_flag - 1) == 0);
        winB = ($urandom_range(0, p_flag - 1) == 0);
      end
    end
    tick();
    rst = 0; start = 0; winA = 0; winB = 0; tie = 0; move_done = 0;
    tick();
    peek();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 Parameter WINS_TO_MATCH, default 3: round wins needed to take the match (1..15).
REQ-002 Parameter RESULT_HOLD, default 4: cycles the round result is held before the next round (1..255).
REQ-003 Parameter TIMEOUT_CYC, default 200: idle cycles allowed per move before forfeit (1..65535).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  level; begin a match from IDLE or DONE.
REQ-007 winA  input  1  game core reports player A (X) won the round.
REQ-008 winB  input  1  game core reports player B (O) won the round.
REQ-009 tie  input  1  game core reports a drawn round.
REQ-010 turn  input  1  game core side to move: 0 = A, 1 = B.
REQ-011 move_done  input  1  one-cycle pulse per accepted play.
REQ-012 game_rst  output  1  one-cycle clear pulse to the game core.
REQ-013 first_player  output  1  side that opens the current round: 0 = A, 1 = B.
REQ-014 scoreA, scoreB  output  4 each  round wins per player.
REQ-015 round  output  4  current round number, first round = 1.
REQ-016 match_over  output  1  high while in DONE.
REQ-017 champion  output  2  00 none, 01 A, 10 B; valid while match_over is high.
REQ-018 timeout  output  1  one-cycle pulse when a move forfeit fires.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, PLAY, HOLD and DONE, all registered.
REQ-020 IDLE SHALL go to CLEAR on start=1, with scores cleared, round=1 and first_player=0.
REQ-021 CLEAR SHALL drive game_rst=1 for exactly one cycle and then go to PLAY.
REQ-022 PLAY SHALL ignore winA/winB/tie in the first PLAY cycle after CLEAR, because core flags are stale.
REQ-023 In PLAY, winA SHALL increment scoreA; winB SHALL increment scoreB; tie SHALL change no score; each of these SHALL then move to HOLD.
REQ-024 If more than one result flag is high in the same cycle, priority SHALL be winA > winB > tie, and only one score SHALL change.
REQ-025 HOLD SHALL last exactly RESULT_HOLD cycles, and result flags SHALL be ignored during HOLD.
REQ-026 On HOLD exit, if scoreA or scoreB equals WINS_TO_MATCH, the FSM SHALL go to DONE and set champion to the player that reached it.
REQ-027 Otherwise, on HOLD exit, round SHALL increment, first_player SHALL toggle, and the FSM SHALL go to CLEAR.
REQ-028 scoreA, scoreB and round SHALL saturate at 15 and never wrap.
REQ-029 DONE SHALL hold all outputs; start=1 in DONE SHALL clear scores and champion, set round=1 and first_player=0, and go to CLEAR.
REQ-030 start SHALL be ignored in CLEAR, PLAY and HOLD.
REQ-031 The move timer SHALL clear on CLEAR, on move_done and on entry to PLAY, and SHALL count every PLAY cycle otherwise.
REQ-032 When the move timer reaches TIMEOUT_CYC-1 in PLAY with no result flag and no move_done that cycle, the block SHALL pulse timeout, score the side opposite turn, and go to HOLD.
REQ-033 A result flag and a timer expiry in the same cycle SHALL resolve in favour of the result flag.
REQ-034 game_rst SHALL be asserted in no state other than CLEAR.

Reset
REQ-035 When rst=1 at a clock edge, the block SHALL enter IDLE with game_rst=0, first_player=0, scoreA=scoreB=0, round=0, match_over=0, champion=00, timeout=0, and all counters at 0.
REQ-036 Reset SHALL override every input, including mid-PLAY and mid-HOLD.

Configuration
REQ-037 Macro MOVE_TIMEOUT_EN: when defined, the move timer and the timeout forfeit (REQ-031..033) SHALL be implemented.
REQ-038 When MOVE_TIMEOUT_EN is undefined, the timer SHALL be absent, timeout SHALL be tied to 0, and PLAY SHALL wait indefinitely for a result flag.

Verification
REQ-039 rst, then start=1 for one cycle -> game_rst high exactly 1 cycle, round=1, first_player=0, FSM in PLAY.
REQ-040 With defaults, three rounds each ending in a winA pulse -> scoreA 1,2,3; round 1,2,3; first_player 0,1,0; then match_over=1 and champion=01, with no fourth game_rst.
REQ-041 winA and winB pulsed in the same cycle -> scoreA=1 and scoreB=0; a tie in the next round -> scores unchanged and round=3.
REQ-042 MOVE_TIMEOUT_EN defined, TIMEOUT_CYC=8, turn=1, no move_done for 8 cycles -> timeout pulse and scoreA=1; repeated move_done every 5 cycles -> no timeout.
REQ-043 rst asserted in HOLD with scoreB=2 -> next cycle IDLE with all scores 0; start ignored while in PLAY.
REQ-044 Sixteen tie rounds with WINS_TO_MATCH=15 -> round saturates at 15 and does not wrap.
